// File: rtl/mux_nch_scan.sv
// Registered N-channel mux: manual strobe select or round-robin scan with dwell; one blank cycle per switch.
// Latency 1 cycle input-to-y; no backpressure, consumer qualifies y with y_valid.
module mux_nch_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH*CHANNELS-1:0] i,
    input  logic [SEL_W-1:0]          s,
    input  logic                      load,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en_mask,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap
);
    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_BLANK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sel_dat;
    logic [SEL_W-1:0] hi_sel;
    logic [SEL_W-1:0] lo_sel;
    logic [SEL_W-1:0] next_sel;
    logic             hi_found;
    logic             s_ok;
    logic             dwell_done;

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_sel == SEL_W'(k)) sel_dat = i[k*WIDTH +: WIDTH];
        end
    end

    // Next enabled channel above cur_sel wins; otherwise wrap to the lowest enabled one.
    always_comb begin
        hi_sel   = cur_sel;
        lo_sel   = cur_sel;
        hi_found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                if (SEL_W'(k) > cur_sel) begin
                    hi_sel   = SEL_W'(k);
                    hi_found = 1'b1;
                end else begin
                    lo_sel = SEL_W'(k);
                end
            end
        end
        next_sel = hi_found ? hi_sel : lo_sel;
    end

    assign s_ok       = (int'(s) < CHANNELS) && (s != cur_sel);
    assign dwell_done = (cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_MANUAL;
            y       <= '0;
            y_valid <= 1'b0;
            cur_sel <= '0;
            wrap    <= 1'b0;
            cnt     <= '0;
        end else begin
            wrap <= 1'b0;
            unique case (state)
                ST_MANUAL: begin
                    cnt <= '0;
                    if (mode) begin
                        state   <= ST_SCAN;
                        y       <= sel_dat;
                        y_valid <= 1'b1;
                    end else if (load && s_ok) begin
                        cur_sel <= s;
                        state   <= ST_BLANK;
                        y_valid <= 1'b0;
                    end else begin
                        y       <= sel_dat;
                        y_valid <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state   <= ST_MANUAL;
                        cnt     <= '0;
                        y       <= sel_dat;
                        y_valid <= 1'b1;
                    end else if (en_mask == '0) begin
                        cnt     <= '0;
                        y       <= sel_dat;
                        y_valid <= 1'b0;
                    end else if (dwell_done && (next_sel != cur_sel)) begin
                        cnt     <= '0;
                        cur_sel <= next_sel;
                        state   <= ST_BLANK;
                        y_valid <= 1'b0;
                        wrap    <= !hi_found;
                    end else begin
                        cnt     <= dwell_done ? '0 : cnt + 1'b1;
                        y       <= sel_dat;
                        y_valid <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    // The blank cycle is the one just output; this edge loads the new channel.
                    state   <= mode ? ST_SCAN : ST_MANUAL;
                    y       <= sel_dat;
                    y_valid <= mode ? (en_mask != '0) : 1'b1;
                end
                default: begin
                    state   <= ST_MANUAL;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_nch_scan.sv
// Directed-vector bench for mux_nch_scan: 4-channel scan instance plus a 5-channel select-range instance.
module tb_mux_nch_scan;
    localparam logic [31:0] ID  = 32'h44332211;
    localparam logic [31:0] I5A = 32'h4433225A;
    localparam logic [3:0]  MB  = 4'b1011;
    localparam logic [3:0]  M1  = 4'b0001;
    localparam int          NV  = 43;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, load, mode;
    logic [1:0]  s;
    logic [3:0]  en_mask;
    logic [31:0] i;
    logic [7:0]  y;
    logic        y_valid;
    logic [1:0]  cur_sel;
    logic        wrap;

    logic        load5, mode5;
    logic [2:0]  s5;
    logic [4:0]  mask5;
    logic [39:0] i5;
    logic [7:0]  y5;
    logic        yv5;
    logic [2:0]  sel5;
    logic        wrap5;

    int checks = 0;
    int failures = 0;

    mux_nch_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut (
        .clk(clk), .rst_n(rst_n), .i(i), .s(s), .load(load), .mode(mode),
        .en_mask(en_mask), .y(y), .y_valid(y_valid), .cur_sel(cur_sel), .wrap(wrap)
    );

    mux_nch_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .i(i5), .s(s5), .load(load5), .mode(mode5),
        .en_mask(mask5), .y(y5), .y_valid(yv5), .cur_sel(sel5), .wrap(wrap5)
    );

    typedef struct {
        logic        rst_n;
        logic        load;
        logic [1:0]  s;
        logic        mode;
        logic [3:0]  mask;
        logic [31:0] i;
        logic [7:0]  y;
        logic        yv;
        logic [1:0]  sel;
        logic        wr;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t v(logic r, logic l, logic [1:0] sv, logic m, logic [3:0] mk,
                               logic [31:0] iv, logic [7:0] ey, logic eyv, logic [1:0] esel,
                               logic ewr);
        vec_t t;
        t.rst_n = r;  t.load = l;  t.s = sv;   t.mode = m; t.mask = mk; t.i = iv;
        t.y     = ey; t.yv   = eyv; t.sel = esel; t.wr = ewr;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; s = '0; mode = 1'b0; en_mask = '0; i = ID;
        load5 = 1'b0; s5 = '0; mode5 = 1'b0; mask5 = '0; i5 = 40'h5544332211;

        //          rst ld s  md mask i     y      yv sel wr
        vecs[0]  = v(0, 0, 0, 0, 0,  ID,  8'h00, 0, 0, 0);
        vecs[1]  = v(0, 0, 0, 0, 0,  ID,  8'h00, 0, 0, 0);
        vecs[2]  = v(1, 0, 0, 0, 0,  ID,  8'h11, 1, 0, 0);
        vecs[3]  = v(1, 0, 0, 0, 0,  I5A, 8'h5A, 1, 0, 0);
        vecs[4]  = v(1, 0, 0, 0, 0,  ID,  8'h11, 1, 0, 0);
        vecs[5]  = v(1, 1, 2, 0, 0,  ID,  8'h11, 0, 2, 0);
        vecs[6]  = v(1, 0, 2, 0, 0,  ID,  8'h33, 1, 2, 0);
        vecs[7]  = v(1, 1, 2, 0, 0,  ID,  8'h33, 1, 2, 0);
        vecs[8]  = v(1, 0, 0, 0, 0,  ID,  8'h33, 1, 2, 0);
        vecs[9]  = v(1, 1, 0, 0, 0,  ID,  8'h33, 0, 0, 0);
        vecs[10] = v(1, 0, 0, 0, 0,  ID,  8'h11, 1, 0, 0);
        vecs[11] = v(1, 0, 0, 1, MB, ID,  8'h11, 1, 0, 0);
        vecs[12] = v(1, 0, 0, 1, MB, ID,  8'h11, 1, 0, 0);
        vecs[13] = v(1, 0, 0, 1, MB, ID,  8'h11, 1, 0, 0);
        vecs[14] = v(1, 0, 0, 1, MB, ID,  8'h11, 0, 1, 0);
        vecs[15] = v(1, 0, 0, 1, MB, ID,  8'h22, 1, 1, 0);
        vecs[16] = v(1, 0, 0, 1, MB, ID,  8'h22, 1, 1, 0);
        vecs[17] = v(1, 0, 0, 1, MB, ID,  8'h22, 1, 1, 0);
        vecs[18] = v(1, 0, 0, 1, MB, ID,  8'h22, 0, 3, 0);
        vecs[19] = v(1, 0, 0, 1, MB, ID,  8'h44, 1, 3, 0);
        vecs[20] = v(1, 0, 0, 1, MB, ID,  8'h44, 1, 3, 0);
        vecs[21] = v(1, 0, 0, 1, MB, ID,  8'h44, 1, 3, 0);
        vecs[22] = v(1, 0, 0, 1, MB, ID,  8'h44, 0, 0, 1);
        vecs[23] = v(1, 0, 0, 1, MB, ID,  8'h11, 1, 0, 0);
        vecs[24] = v(1, 1, 2, 1, MB, ID,  8'h11, 1, 0, 0);
        vecs[25] = v(1, 0, 0, 1, MB, ID,  8'h11, 1, 0, 0);
        vecs[26] = v(1, 0, 0, 1, MB, ID,  8'h11, 0, 1, 0);
        vecs[27] = v(1, 0, 0, 1, M1, ID,  8'h22, 1, 1, 0);
        vecs[28] = v(1, 0, 0, 1, M1, ID,  8'h22, 1, 1, 0);
        vecs[29] = v(1, 0, 0, 1, M1, ID,  8'h22, 1, 1, 0);
        vecs[30] = v(1, 0, 0, 1, M1, ID,  8'h22, 0, 0, 1);
        for (int n = 31; n <= 38; n++) vecs[n] = v(1, 0, 0, 1, M1, ID, 8'h11, 1, 0, 0);
        vecs[39] = v(1, 0, 0, 1, 0,  ID,  8'h11, 0, 0, 0);
        vecs[40] = v(1, 0, 0, 1, 0,  I5A, 8'h5A, 0, 0, 0);
        vecs[41] = v(1, 0, 0, 1, M1, ID,  8'h11, 1, 0, 0);
        vecs[42] = v(1, 0, 0, 0, M1, ID,  8'h11, 1, 0, 0);

        for (int n = 0; n < NV; n++) begin
            rst_n = vecs[n].rst_n; load = vecs[n].load; s = vecs[n].s;
            mode = vecs[n].mode; en_mask = vecs[n].mask; i = vecs[n].i;
            tick();
            check("y",       n, 32'(y),       32'(vecs[n].y));
            check("y_valid", n, 32'(y_valid), 32'(vecs[n].yv));
            check("cur_sel", n, 32'(cur_sel), 32'(vecs[n].sel));
            check("wrap",    n, 32'(wrap),    32'(vecs[n].wr));
        end

        // Reset landing in the blank cycle right after a scan switch.
        load = 1'b0; mode = 1'b1; en_mask = MB; i = ID;
        repeat (3) tick();
        tick();
        check("preblank_valid", 100, 32'(y_valid), 32'd0);
        check("preblank_sel",   100, 32'(cur_sel), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rstblank_y",     101, 32'(y),       32'h00);
        check("rstblank_valid", 101, 32'(y_valid), 32'd0);
        check("rstblank_sel",   101, 32'(cur_sel), 32'd0);
        check("rstblank_wrap",  101, 32'(wrap),    32'd0);
        rst_n = 1'b1; mode = 1'b0;
        tick();
        check("resume_y",     102, 32'(y),       32'h11);
        check("resume_valid", 102, 32'(y_valid), 32'd1);
        check("resume_sel",   102, 32'(cur_sel), 32'd0);
        tick();
        check("resume2_valid", 103, 32'(y_valid), 32'd1);

        // Five-channel instance: select range edges.
        check("c5_idle_y",   200, 32'(y5),  32'h11);
        check("c5_idle_sel", 200, 32'(sel5), 32'd0);
        load5 = 1'b1; s5 = 3'd6;
        tick();
        check("c5_oor_y",     201, 32'(y5),   32'h11);
        check("c5_oor_valid", 201, 32'(yv5),  32'd1);
        check("c5_oor_sel",   201, 32'(sel5), 32'd0);
        s5 = 3'd4;
        tick();
        check("c5_top_sel",   202, 32'(sel5), 32'd4);
        check("c5_top_valid", 202, 32'(yv5),  32'd0);
        check("c5_top_y",     202, 32'(y5),   32'h11);
        s5 = 3'd5;
        tick();
        check("c5_new_y",     203, 32'(y5),   32'h55);
        check("c5_new_valid", 203, 32'(yv5),  32'd1);
        check("c5_new_sel",   203, 32'(sel5), 32'd4);
        check("c5_wrap",      203, 32'(wrap5), 32'd0);
        load5 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_nch_scan.md
# mux_nch_scan

Parametrised, registered N-channel multiplexer, successor to the basic 2:1 mux. It selects one of CHANNELS input words of WIDTH bits and drives it onto a registered output. Two modes: manual (select loaded by strobe) and auto-scan (round-robin over a channel mask with a programmable dwell). Every channel switch inserts one break-before-make blanking cycle. It sits between multi-source data inputs and a single downstream consumer that qualifies data with Y_VALID.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2); SEL_W = max(1, clog2(CHANNELS)), derived
- DWELL, 8, valid cycles spent on each channel in scan mode (≥1)

- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  synchronous, active-low reset
- I  in  WIDTH*CHANNELS  flattened inputs; channel k = I[k*WIDTH +: WIDTH]
- S  in  SEL_W  manual channel select
- LOAD  in  1  manual select strobe, sampled each edge
- MODE  in  1  0 = manual, 1 = scan
- EN_MASK  in  CHANNELS  channels included in the scan
- Y  out  WIDTH  registered selected data
- Y_VALID  out  1  Y holds current-channel data
- CUR_SEL  out  SEL_W  currently selected channel
- WRAP  out  1  one-cycle pulse when a scan advance wraps to a lower index

## Operation
- Reset (RST_N=0 at an edge, overrides everything): Y=0, Y_VALID=0, CUR_SEL=0, WRAP=0, dwell counter=0, state MANUAL.
- States: MANUAL, SCAN, BLANK. At each edge in MANUAL or SCAN, the next state follows MODE.
- MANUAL: Y<=I[CUR_SEL], Y_VALID<=1. A LOAD=1 with S<CHANNELS and S!=CUR_SEL sets CUR_SEL<=S and enters BLANK. LOAD with S==CUR_SEL or S>=CHANNELS is ignored.
- SCAN: LOAD is ignored.
  - When EN_MASK!=0: Y<=I[CUR_SEL] and Y_VALID<=1. The counter increments once per SCAN cycle.
  - At counter==DWELL-1 the counter clears and the next enabled channel is chosen, searching ascending from CUR_SEL+1 modulo CHANNELS.
  - If that channel differs from CUR_SEL: CUR_SEL<=next and enter BLANK. WRAP<=1 if next<CUR_SEL.
  - If the only enabled channel is CUR_SEL: no switch, no BLANK, no WRAP.
  - A current channel absent from the mask stays selected until the first dwell expiry.
  - When EN_MASK==0: Y still tracks I[CUR_SEL], Y_VALID<=0, the counter is held at 0, and CUR_SEL holds.
- BLANK lasts exactly one cycle. Y holds its previous value, Y_VALID<=0, and the counter is held. The next state follows MODE at that edge.
- MODE change: the counter clears to 0, CUR_SEL is kept, and no blanking occurs.
- WRAP is 0 in every cycle except the one following the wrapping advance.

## Timing
- Data latency is 1 cycle: I[CUR_SEL] sampled at edge n appears on Y after edge n.
- Manual switch, with LOAD sampled at edge n:
  - After edge n: CUR_SEL=new, Y_VALID=0, Y=old data.
  - After edge n+1: Y=I[new], Y_VALID=1.
- Scan, with DWELL=D and k channels enabled: each channel gets D valid cycles then 1 blank. The period is k*(D+1) cycles.
- DWELL=1 in scan gives alternating valid and blank cycles.
- CUR_SEL changes on the same edge that Y_VALID falls. WRAP asserts on that same edge.
- Reset mid-operation, including during BLANK: all outputs take reset values after that edge. Operation resumes in MANUAL on channel 0.

## Test plan
Parameters WIDTH=8, CHANNELS=4, DWELL=3, with I = {0x44,0x33,0x22,0x11} (channel 0 = 0x11) unless stated.

- Reset: hold RST_N=0 for 2 edges -> Y=0x00, Y_VALID=0, CUR_SEL=0, WRAP=0. First edge after release -> Y=0x11, Y_VALID=1. Then change channel 0 to 0x5A -> Y=0x5A one cycle later.
- Manual switch: LOAD=1, S=2 for one cycle -> next cycle CUR_SEL=2, Y_VALID=0, Y=0x11; following cycle Y=0x33, Y_VALID=1. LOAD, S=2 again -> no blank.
- Out-of-range select (CHANNELS=5, SEL_W=3 instance): LOAD with S=6 -> CUR_SEL, Y and Y_VALID unchanged.
- Scan with MODE=1, EN_MASK=4'b1011 starting on channel 0:
  - Y_VALID pattern is 1,1,1,0 repeating.
  - CUR_SEL sequence is 0,1,3,0.
  - WRAP=1 only in the blank cycle entering channel 0.
  - Y shows 0x11, 0x22, 0x44 in turn.
- Scan degenerate masks:
  - EN_MASK=4'b0001 on channel 0 -> Y_VALID stays 1 indefinitely, WRAP never asserts.
  - EN_MASK=0 -> Y_VALID=0 and CUR_SEL frozen. Restoring 4'b0001 -> Y_VALID=1 next cycle.
- Reset mid-blank: assert RST_N=0 on the edge after a scan switch -> reset values. On release, MODE=0 -> Y=0x11, CUR_SEL=0.
